button_conditioner: RTL and testbench

Upstream conditioning stage for the five board push-buttons feeding the minesweeper game logic and VGA renderer. Synchronises and debounces the raw button inputs, then turns them into single-cycle action pulses. The directional buttons produce `button_u/d/r/l` pulses. The centre button is classified into short-press and long-press pulses, which drive `button_c_short` / `button_c_long` of the game FSM. Runs entirely in the 36 MHz `pixel_clk` domain.

---
 rtl/button_pkg.sv | 17 +
 rtl/btn_debounce.sv | 40 ++++
 rtl/button_conditioner.sv | 155 +++++++++++++++
 tb/tb_button_conditioner.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared definitions for the push-button conditioning path: button indices and centre FSM states.
package button_pkg;

    localparam int BTN_C     = 0;
    localparam int BTN_U     = 1;
    localparam int BTN_D     = 2;
    localparam int BTN_R     = 3;
    localparam int BTN_L     = 4;
    localparam int BTN_COUNT = 5;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        LONG_DONE
    } c_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus consecutive-cycle debounce for a single raw button.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 180000
) (
    input  logic pixel_clk,
    input  logic rst,
    input  logic btn_raw,
    output logic stable
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] count;

    // The level is accepted on the edge that would bring the count to DEBOUNCE_CYCLES,
    // so the counter never exceeds DEBOUNCE_CYCLES-1 and cannot wrap.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            count  <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            if (sync2 == stable) begin
                count <= '0;
            end else if (count >= LAST) begin
                stable <= sync2;
                count  <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Debounces the five board buttons and turns them into one-cycle action pulses.
// Optional directional auto-repeat is enabled by defining BTN_AUTOREPEAT_EN.
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 180000,
    parameter int LONG_PRESS_CYCLES = 36000000
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY      = 14400000,
    parameter int REPEAT_PERIOD     = 3600000
`endif
) (
    input  logic                 pixel_clk,
    input  logic                 rst,
    input  logic [BTN_COUNT-1:0] btn_raw_i,
    output logic [BTN_COUNT-1:0] btn_level_o,
    output logic                 button_u,
    output logic                 button_d,
    output logic                 button_r,
    output logic                 button_l,
    output logic                 button_c_short,
    output logic                 button_c_long
);

    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_PRESS_CYCLES - 2);

    logic [BTN_COUNT-1:0] stable;
    logic [BTN_COUNT-1:0] stable_d;
    logic [BTN_COUNT-1:0] rise;
    logic                 c_fall;
    logic [BTN_L:BTN_U]   dir_pulse;
    c_state_t             c_state;
    logic [HW-1:0]        hold_cnt;

    for (genvar i = 0; i < BTN_COUNT; i++) begin : g_deb
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .pixel_clk(pixel_clk),
            .rst      (rst),
            .btn_raw  (btn_raw_i[i]),
            .stable   (stable[i])
        );
    end

    assign btn_level_o = stable;
    assign rise        = stable & ~stable_d;
    assign c_fall      = ~stable[BTN_C] & stable_d[BTN_C];

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            stable_d <= '0;
        end else begin
            stable_d <= stable;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(RPT_MAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    for (genvar i = BTN_U; i <= BTN_L; i++) begin : g_rpt
        logic [RW-1:0] rpt_cnt;
        logic          rpt_first;
        logic          pulse;

        // rpt_cnt measures cycles since the last pulse; the first gap is REPEAT_DELAY,
        // later gaps REPEAT_PERIOD. Dropping the level parks the timer immediately.
        always_ff @(posedge pixel_clk) begin
            if (rst) begin
                rpt_cnt   <= '0;
                rpt_first <= 1'b1;
                pulse     <= 1'b0;
            end else begin
                pulse <= 1'b0;
                if (rise[i]) begin
                    pulse     <= 1'b1;
                    rpt_cnt   <= '0;
                    rpt_first <= 1'b1;
                end else if (stable[i]) begin
                    if (rpt_cnt >= (rpt_first ? DELAY_LAST : PERIOD_LAST)) begin
                        pulse     <= 1'b1;
                        rpt_cnt   <= '0;
                        rpt_first <= 1'b0;
                    end else begin
                        rpt_cnt <= rpt_cnt + 1'b1;
                    end
                end else begin
                    rpt_cnt   <= '0;
                    rpt_first <= 1'b1;
                end
            end
        end

        assign dir_pulse[i] = pulse;
    end
`else
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            dir_pulse <= '0;
        end else begin
            dir_pulse <= rise[BTN_L:BTN_U];
        end
    end
`endif

    assign button_u = dir_pulse[BTN_U];
    assign button_d = dir_pulse[BTN_D];
    assign button_r = dir_pulse[BTN_R];
    assign button_l = dir_pulse[BTN_L];

    // The long pulse is raised on the edge that would bring hold_cnt to LONG_PRESS_CYCLES-1;
    // a release seen on that same edge wins, so one press never yields both pulses.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            c_state        <= IDLE;
            hold_cnt       <= '0;
            button_c_short <= 1'b0;
            button_c_long  <= 1'b0;
        end else begin
            button_c_short <= 1'b0;
            button_c_long  <= 1'b0;
            case (c_state)
                IDLE: begin
                    if (rise[BTN_C]) begin
                        c_state  <= HELD;
                        hold_cnt <= '0;
                    end
                end
                HELD: begin
                    if (c_fall) begin
                        button_c_short <= 1'b1;
                        c_state        <= IDLE;
                    end else if (hold_cnt >= HOLD_FIRE) begin
                        button_c_long <= 1'b1;
                        c_state       <= LONG_DONE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                LONG_DONE: begin
                    if (c_fall) begin
                        c_state <= IDLE;
                    end
                end
                default: c_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: scenario table, reset corner case and random model check.
// Expectations follow BTN_AUTOREPEAT_EN when it is defined for the build.
module tb_button_conditioner;

    localparam int D    = 4;
    localparam int LP   = 20;
`ifdef BTN_AUTOREPEAT_EN
    localparam int RD   = 10;
    localparam int RP   = 5;
    localparam int REPS = 5;
`else
    localparam int REPS = 1;
`endif
    localparam int MAXT  = 512;
    localparam int SCN_T = 80;
    localparam int RND_T = 400;
    localparam int NV    = 10;

    logic       pixel_clk;
    logic       rst;
    logic [4:0] btn_raw_i;
    logic [4:0] btn_level_o;
    logic       button_u, button_d, button_r, button_l;
    logic       button_c_short, button_c_long;

    button_conditioner #(
        .DEBOUNCE_CYCLES  (D),
        .LONG_PRESS_CYCLES(LP)
`ifdef BTN_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY     (RD),
        .REPEAT_PERIOD    (RP)
`endif
    ) dut (
        .pixel_clk     (pixel_clk),
        .rst           (rst),
        .btn_raw_i     (btn_raw_i),
        .btn_level_o   (btn_level_o),
        .button_u      (button_u),
        .button_d      (button_d),
        .button_r      (button_r),
        .button_l      (button_l),
        .button_c_short(button_c_short),
        .button_c_long (button_c_long)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    // Observation vector: [4:0] levels, [5] u, [6] d, [7] r, [8] l, [9] c_short, [10] c_long.
    typedef struct {
        string name;
        int    btn;
        int    len;
        bit    toggle;
        int    out_bit;
        int    exp_first;
        int    exp_count;
    } vec_t;

    vec_t        vecs [NV];
    logic [4:0]  raw_seq [MAXT];
    logic [10:0] obs [MAXT];
    logic [10:0] exp_v [MAXT];
    logic [4:0]  st [MAXT];
    int          checks;
    int          failures;
    int          first;
    int          count;

    function automatic logic [10:0] sample();
        return {button_c_long, button_c_short, button_l, button_r, button_d, button_u, btn_level_o};
    endfunction

    function automatic logic raw_at(input int t, input int b);
        return (t < 0) ? 1'b0 : raw_seq[t][b];
    endfunction

    function automatic logic st_at(input int t, input int b);
        return (t < 0) ? 1'b0 : st[t][b];
    endfunction

    function automatic int fall_after(input int s, input int b, input int n);
        for (int k = s + 1; k < n; k++) begin
            if (!st[k][b]) return k;
        end
        return n + 1000;
    endfunction

    task automatic check_output(input string name, input logic [10:0] actual, input logic [10:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic check_int(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        btn_raw_i = '0;
        repeat (3) @(posedge pixel_clk);
        #1;
        check_output("reset_state", sample(), 11'd0);
        rst = 1'b0;
    endtask

    task automatic apply_stimulus(input int n);
        for (int t = 0; t < n; t++) begin
            btn_raw_i = raw_seq[t];
            @(posedge pixel_clk);
            #1;
            obs[t] = sample();
        end
    endtask

    task automatic scan_bit(input int bit_idx, input int lo, input int hi);
        first = -1;
        count = 0;
        for (int t = lo; t < hi; t++) begin
            if (obs[t][bit_idx]) begin
                if (first < 0) first = t;
                count++;
            end
        end
    endtask

    task automatic gen_random(input int n);
        for (int b = 0; b < 5; b++) begin
            int   t = 0;
            logic v = 1'b0;
            while (t < n) begin
                int len = $urandom_range((b == 0) ? 40 : 12, 1);
                for (int k = 0; k < len && t < n; k++) begin
                    raw_seq[t][b] = v;
                    t++;
                end
                v = ~v;
            end
        end
    endtask

    // Reference: a level is accepted once D consecutive synchronised samples disagree with it;
    // pulses are then placed at fixed offsets from the accepted rise/fall edges.
    task automatic build_expected(input int n);
        for (int t = 0; t < n; t++) exp_v[t] = '0;
        for (int b = 0; b < 5; b++) begin
            logic cur = 1'b0;
            for (int t = 0; t < n; t++) begin
                bit flip = 1'b1;
                for (int j = 0; j < D; j++) begin
                    if (raw_at(t - 2 - j, b) == cur) flip = 1'b0;
                end
                if (flip) cur = ~cur;
                st[t][b] = cur;
            end
        end
        for (int t = 0; t < n; t++) exp_v[t][4:0] = st[t];
        for (int b = 1; b < 5; b++) begin
            for (int s = 0; s < n; s++) begin
                if (st_at(s, b) && !st_at(s - 1, b)) begin
                    if (s + 1 < n) exp_v[s + 1][4 + b] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                    begin
                        int f   = fall_after(s, b, n);
                        int e   = s + 1 + RD;
                        while (e <= f && e < n) begin
                            exp_v[e][4 + b] = 1'b1;
                            e = e + RP;
                        end
                    end
`endif
                end
            end
        end
        for (int s = 0; s < n; s++) begin
            if (st_at(s, 0) && !st_at(s - 1, 0)) begin
                int f = fall_after(s, 0, n);
                if (f + 1 <= s + LP) begin
                    if (f + 1 < n) exp_v[f + 1][9] = 1'b1;
                end else if (s + LP < n) begin
                    exp_v[s + LP][10] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        btn_raw_i = '0;

        vecs[0] = '{"u_pulse",        1, 30, 1'b0, 5,  6,  REPS};
        vecs[1] = '{"u_level",        1, 30, 1'b0, 1,  5,  30};
        vecs[2] = '{"r_glitch_pulse", 3, 40, 1'b1, 7,  -1, 0};
        vecs[3] = '{"r_glitch_level", 3, 40, 1'b1, 3,  -1, 0};
        vecs[4] = '{"c_short",        0, 15, 1'b0, 9,  21, 1};
        vecs[5] = '{"c_short_nolong", 0, 15, 1'b0, 10, -1, 0};
        vecs[6] = '{"c_long",         0, 40, 1'b0, 10, 25, 1};
        vecs[7] = '{"c_long_noshort", 0, 40, 1'b0, 9,  -1, 0};
        vecs[8] = '{"c_no_dir",       0, 40, 1'b0, 6,  -1, 0};
        vecs[9] = '{"l_pulse",        4, 30, 1'b0, 8,  6,  REPS};

        for (int i = 0; i < NV; i++) begin
            do_reset();
            for (int t = 0; t < MAXT; t++) raw_seq[t] = '0;
            for (int t = 0; t < vecs[i].len; t++) begin
                if (!vecs[i].toggle || ((t / 3) % 2 == 0)) raw_seq[t][vecs[i].btn] = 1'b1;
            end
            apply_stimulus(SCN_T);
            scan_bit(vecs[i].out_bit, 0, SCN_T);
            check_int({vecs[i].name, "_first"}, first, vecs[i].exp_first);
            check_int({vecs[i].name, "_count"}, count, vecs[i].exp_count);
        end

        // Reset pulse while the centre FSM is HELD, with the button kept down throughout.
        do_reset();
        for (int t = 0; t < 60; t++) begin
            btn_raw_i = 5'b00001;
            rst       = (t == 10);
            @(posedge pixel_clk);
            #1;
            obs[t] = sample();
        end
        rst = 1'b0;
        check_output("rst_pre_held", obs[9], 11'h001);
        check_output("rst_clears_all", obs[10], 11'h000);
        scan_bit(0, 10, 60);
        check_int("rst_reaccept_first", first, 16);
        scan_bit(10, 0, 60);
        check_int("rst_long_first", first, 36);
        check_int("rst_long_count", count, 1);
        scan_bit(9, 0, 60);
        check_int("rst_short_count", count, 0);

        do_reset();
        gen_random(RND_T);
        apply_stimulus(RND_T);
        build_expected(RND_T);
        for (int t = 0; t < RND_T; t++) begin
            check_output($sformatf("rand_t%0d", t), obs[t], exp_v[t]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
